deserializer_multilane: RTL and testbench

//  Parametrised successor serial-to-parallel converter: NUM_LANES serial bits per enable beat,
//  MSB- or LSB-first ordering, optional continuous framing, output FIFO with valid/ready

---
 rtl/deserializer_multilane.sv | 150 +++++++++++++++
 tb/tb_deserializer_multilane.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_multilane.sv
// deserializer_multilane
//   Collects NUM_LANES serial bits per enable beat into DATA_WIDTH-bit words
//   and queues completed words in a small output FIFO.
//
//   Output handshake: valid_o is high whenever the FIFO holds a word, and
//   parallel_out_o then shows the head word. The head is consumed on every
//   rising clk_i edge where valid_o && ready_i. While ready_i is low, valid_o
//   and parallel_out_o hold their values. A word that completes while the
//   FIFO is full and no pop happens in the same cycle is dropped and flagged
//   on overflow_o for one cycle.
//
//   The FSM state is visible on busy_o (SHIFT when high).
module deserializer_multilane #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 1,
  parameter int LSB_FIRST  = 0,
  parameter int CONTINUOUS = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_LANES-1:0]          serial_in_i,
  input  logic                          enable_i,
  input  logic                          start_i,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         parallel_out_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int BEATS = DATA_WIDTH / NUM_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Reject parameter sets the datapath cannot represent.
  if ((DATA_WIDTH % NUM_LANES) != 0) begin : g_bad_width
    $error("deserializer_multilane: DATA_WIDTH must be a multiple of NUM_LANES");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("deserializer_multilane: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_eff;
  logic [DATA_WIDTH-1:0] sreg_q, shifted;
  logic                  started_q;
  logic                  start_eff, active, beat, done, err_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  pop, push_ok, ovf_d;
  logic                  ferr_q, ovf_q;

  // Shift register input: the first beat of a word ends at the MSB end when
  // shifting left, or at the LSB end when shifting right. Lane order within a
  // beat is kept as-is.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shifted = (sreg_q >> NUM_LANES) |
                (DATA_WIDTH'(serial_in_i) << (DATA_WIDTH - NUM_LANES));
    end else begin
      shifted = (sreg_q << NUM_LANES) | DATA_WIDTH'(serial_in_i);
    end
  end

  // Framing FSM: decides whether this cycle is a beat, and whether it finishes a word.
  always_comb begin
    // An explicit start always begins a frame; in continuous mode an idle
    // beat after the first start also begins one.
    start_eff = start_i |
                ((CONTINUOUS != 0) & started_q & (state_q == ST_IDLE) & enable_i);
    cnt_eff   = start_eff ? '0 : cnt_q;
    active    = start_eff | (state_q == ST_SHIFT);
    beat      = active & enable_i;
    done      = beat & (cnt_eff == CNT_W'(BEATS - 1));
    err_d     = start_i & (state_q == ST_SHIFT) & (cnt_q != '0);
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (active) begin
      if (done) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = beat ? (cnt_eff + CNT_W'(1)) : cnt_eff;
      end
    end
  end

  // FSM, beat counter, shift register and start-seen flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (beat) sreg_q <= shifted;
      if (start_i) started_q <= 1'b1;
    end
  end

  // FIFO control: a pop frees a slot for a push in the same cycle, even when full.
  always_comb begin
    pop     = (level_q != '0) & ready_i;
    push_ok = done & ((level_q != LW'(FIFO_DEPTH)) | pop);
    ovf_d   = done & ~push_ok;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  // FIFO pointers, level and one-cycle status pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ferr_q  <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents only matter where the level says a word is present.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= shifted;
  end

  assign valid_o        = (level_q != '0);
  assign parallel_out_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o         = (state_q == ST_SHIFT);
  assign frame_err_o    = ferr_q;
  assign overflow_o     = ovf_q;
  assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_deserializer_multilane.sv
// Bench for deserializer_multilane: four instances with different lane
// counts, bit orders and framing modes share one stimulus stream; a
// beat-placement reference model with per-instance expected queues
// predicts every output after every clock edge.
module tb_deserializer_multilane;

  localparam int ND    = 4;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] ser    = 2'b00;
  logic       enable = 1'b0;
  logic       start  = 1'b0;
  logic       ready  = 1'b0;

  logic [7:0] pout  [ND];
  logic       valid [ND];
  logic       busy  [ND];
  logic       ferr  [ND];
  logic       ovf   [ND];
  logic [1:0] lvl   [ND];

  int total = 0;
  int bad   = 0;

  // instance configuration: lanes, LSB-first, continuous
  int nl   [ND] = '{1, 2, 2, 1};
  bit lsbf [ND] = '{0, 1, 0, 0};
  bit cont [ND] = '{0, 0, 0, 1};

  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(1), .LSB_FIRST(0), .CONTINUOUS(0), .FIFO_DEPTH(DEPTH)) u_d0 (
    .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(ser[0:0]), .enable_i(enable), .start_i(start),
    .ready_i(ready), .parallel_out_o(pout[0]), .valid_o(valid[0]), .busy_o(busy[0]),
    .frame_err_o(ferr[0]), .overflow_o(ovf[0]), .fifo_level_o(lvl[0]));
  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(2), .LSB_FIRST(1), .CONTINUOUS(0), .FIFO_DEPTH(DEPTH)) u_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(ser), .enable_i(enable), .start_i(start),
    .ready_i(ready), .parallel_out_o(pout[1]), .valid_o(valid[1]), .busy_o(busy[1]),
    .frame_err_o(ferr[1]), .overflow_o(ovf[1]), .fifo_level_o(lvl[1]));
  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(2), .LSB_FIRST(0), .CONTINUOUS(0), .FIFO_DEPTH(DEPTH)) u_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(ser), .enable_i(enable), .start_i(start),
    .ready_i(ready), .parallel_out_o(pout[2]), .valid_o(valid[2]), .busy_o(busy[2]),
    .frame_err_o(ferr[2]), .overflow_o(ovf[2]), .fifo_level_o(lvl[2]));
  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(1), .LSB_FIRST(0), .CONTINUOUS(1), .FIFO_DEPTH(DEPTH)) u_d3 (
    .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(ser[0:0]), .enable_i(enable), .start_i(start),
    .ready_i(ready), .parallel_out_o(pout[3]), .valid_o(valid[3]), .busy_o(busy[3]),
    .frame_err_o(ferr[3]), .overflow_o(ovf[3]), .fifo_level_o(lvl[3]));

  // ---------------- reference model / scoreboard ----------------
  bit         m_in      [ND];
  int         m_cnt     [ND];
  logic [7:0] m_acc     [ND];
  bit         m_started [ND];
  bit         e_err     [ND];
  bit         e_ovf     [ND];
  logic [7:0] exp_q     [ND][$];

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_in[d] = 0; m_cnt[d] = 0; m_acc[d] = 8'h00; m_started[d] = 0;
      e_err[d] = 0; e_ovf[d] = 0;
      exp_q[d].delete();
    end
  endtask

  // One clock edge for instance d, using the inputs driven across that edge.
  task automatic model_step(input int d);
    bit start_eff;
    bit done;
    bit pop;
    int pos;
    e_err[d] = 0;
    e_ovf[d] = 0;
    done = 0;
    pop = (exp_q[d].size() > 0) && ready;
    start_eff = start || (cont[d] && m_started[d] && !m_in[d] && enable);
    if (start_eff) begin
      if (start && m_in[d] && m_cnt[d] != 0) e_err[d] = 1;
      if (start) m_started[d] = 1;
      m_in[d] = 1; m_cnt[d] = 0; m_acc[d] = 8'h00;
    end
    if (m_in[d] && enable) begin
      // beat k lands at bit k*NL (LSB first) or 8-(k+1)*NL (MSB first)
      pos = lsbf[d] ? m_cnt[d] * nl[d] : 8 - (m_cnt[d] + 1) * nl[d];
      for (int i = 0; i < nl[d]; i++) m_acc[d][pos + i] = ser[i];
      m_cnt[d]++;
      if (m_cnt[d] == 8 / nl[d]) begin
        done = 1; m_in[d] = 0; m_cnt[d] = 0;
      end
    end
    if (pop) void'(exp_q[d].pop_front());
    if (done) begin
      if (exp_q[d].size() < DEPTH) exp_q[d].push_back(m_acc[d]);
      else e_ovf[d] = 1;
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [7:0] act, input logic [7:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, act, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] eh;
    for (int d = 0; d < ND; d++) begin
      eh = (exp_q[d].size() > 0) ? exp_q[d][0] : 8'h00;
      chk("valid",     d, 8'(valid[d]), 8'(exp_q[d].size() > 0));
      chk("data",      d, pout[d], eh);
      chk("level",     d, 8'(lvl[d]), 8'(exp_q[d].size()));
      chk("busy",      d, 8'(busy[d]), 8'(m_in[d]));
      chk("frame_err", d, 8'(ferr[d]), 8'(e_err[d]));
      chk("overflow",  d, 8'(ovf[d]), 8'(e_ovf[d]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int d = 0; d < ND; d++) model_step(d);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy, input int n);
    start = 0; enable = 0; ready = rdy;
    repeat (n) cycle();
  endtask

  // Beats k0..k1 of word w, MSB first on lane 0; lane 1 carries random bits.
  task automatic send_bits(input logic [7:0] w, input int k0, input int k1, input bit st,
                           input bit rdy_body, input bit rdy_last);
    for (int k = k0; k <= k1; k++) begin
      start  = st && (k == k0);
      enable = 1;
      ser    = {1'($urandom_range(0, 1)), w[7 - k]};
      ready  = (k == 7) ? rdy_last : rdy_body;
      cycle();
    end
    start = 0; enable = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] b2 [4];
    int got;
    int any_valid;
    b2 = '{2'b01, 2'b10, 2'b11, 2'b00};

    // reset state
    #1 rst_n = 0;
    #1 model_reset();
    check_all();
    idle(0, 2);
    rst_n = 1;
    idle(0, 2);

    // 1: single-lane MSB-first word
    send_bits(8'hB2, 0, 7, 1, 0, 0);
    chk("t1_valid", 0, 8'(valid[0]), 8'd1);
    chk("t1_data",  0, pout[0], 8'hB2);
    chk("t1_level", 0, 8'(lvl[0]), 8'd1);
    idle(1, 4);

    // 2: two lanes, LSB-first and MSB-first placement
    ready = 0;
    for (int k = 0; k < 4; k++) begin
      start = (k == 0); enable = 1; ser = b2[k];
      cycle();
    end
    start = 0; enable = 0;
    chk("t2_lsb_first", 1, pout[1], 8'h39);
    chk("t2_msb_first", 2, pout[2], 8'h6C);
    idle(1, 4);

    // 3: restart mid-frame
    send_bits(8'hFF, 0, 2, 1, 0, 0);
    start = 1; enable = 1; ser = {1'($urandom_range(0, 1)), 1'b0}; ready = 0;
    cycle();
    chk("t3_frame_err", 0, 8'(ferr[0]), 8'd1);
    send_bits(8'h5A, 1, 7, 0, 0, 0);
    chk("t3_data",  0, pout[0], 8'h5A);
    chk("t3_level", 0, 8'(lvl[0]), 8'd1);
    idle(1, 4);

    // 4: backpressure and overflow
    send_bits(8'hA1, 0, 7, 1, 0, 0);
    send_bits(8'hA2, 0, 7, 1, 0, 0);
    send_bits(8'hA3, 0, 7, 1, 0, 0);
    chk("t4_overflow", 0, 8'(ovf[0]), 8'd1);
    chk("t4_level",    0, 8'(lvl[0]), 8'd2);
    chk("t4_head",     0, pout[0], 8'hA1);
    idle(0, 2);
    chk("t4_hold",     0, pout[0], 8'hA1);
    idle(1, 1);
    chk("t4_second",   0, pout[0], 8'hA2);
    idle(1, 1);
    chk("t4_empty",    0, 8'(valid[0]), 8'd0);
    idle(1, 2);

    // 5: word completes into a full FIFO on the same edge as a pop
    send_bits(8'hA4, 0, 7, 1, 0, 0);
    send_bits(8'hA5, 0, 7, 1, 0, 0);
    send_bits(8'hA6, 0, 7, 1, 0, 1);
    chk("t5_no_overflow", 0, 8'(ovf[0]), 8'd0);
    chk("t5_level",       0, 8'(lvl[0]), 8'd2);
    chk("t5_head",        0, pout[0], 8'hA5);
    idle(1, 1);
    chk("t5_next",        0, pout[0], 8'hA6);
    idle(1, 3);

    // 6: continuous framing, then async reset mid-frame
    got = 0;
    ready = 1;
    for (int k = 0; k < 24; k++) begin
      start = (k == 0); enable = 1; ser = 2'($urandom_range(0, 3));
      cycle();
      if (valid[3]) got++;
    end
    chk("t6_words", 3, 8'(got), 8'd3);
    for (int k = 0; k < 5; k++) begin
      start = (k == 0); enable = 1; ser = 2'($urandom_range(0, 3));
      cycle();
    end
    start = 0;
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("t6_rst_busy", 3, 8'(busy[3]), 8'd0);
    cycle();
    cycle();
    rst_n = 1;
    any_valid = 0;
    for (int k = 0; k < 16; k++) begin
      enable = 1; ser = 2'($urandom_range(0, 3));
      cycle();
      if (valid[3]) any_valid++;
    end
    chk("t6_no_valid", 3, 8'(any_valid), 8'd0);
    idle(1, 2);

    // random traffic
    repeat (600) begin
      start  = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 3) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      ser    = 2'($urandom_range(0, 3));
      cycle();
    end
    idle(1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
